// File: rtl/alu_reservation_station.sv
// rtl/alu_reservation_station.sv - four-entry ALU reservation station with CDB wakeup and registered issue
// Define ALU_RS_AGE_PRIORITY_EN for oldest-first selection; otherwise lowest-index eligible wins.
module alu_reservation_station #(
  parameter int WIDTH   = 31,
  parameter int A_WIDTH = 3,
  parameter int ROB     = 2,
  parameter int ALU     = 3
) (
  input  logic               clk,
  input  logic               resetN,
  input  logic               flush,
  input  logic [ALU:0]       ALURequests,
  input  logic [WIDTH:0]     value1,
  input  logic [WIDTH:0]     value2,
  input  logic               ready1,
  input  logic               ready2,
  input  logic [ROB:0]       rob1,
  input  logic [ROB:0]       rob2,
  input  logic [ROB:0]       destRob,
  input  logic [A_WIDTH:0]   aluCntrl,
  input  logic               cdbValid,
  input  logic [ROB:0]       cdbTag,
  input  logic [WIDTH:0]     cdbValue,
  input  logic               aluReady,
  output logic [ALU:0]       ALUBusyVector,
  output logic               issueValid,
  output logic [WIDTH:0]     issueA,
  output logic [WIDTH:0]     issueB,
  output logic [A_WIDTH:0]   issueCntrl,
  output logic [ROB:0]       issueRob
);
  localparam int N  = ALU + 1;
  localparam int SW = (N > 1) ? $clog2(N) : 1;

  logic [ALU:0]     r_valid;
  logic [ALU:0]     r_rdy1;
  logic [ALU:0]     r_rdy2;
  logic [WIDTH:0]   r_val1  [N];
  logic [WIDTH:0]   r_val2  [N];
  logic [ROB:0]     r_tag1  [N];
  logic [ROB:0]     r_tag2  [N];
  logic [A_WIDTH:0] r_cntrl [N];
  logic [ROB:0]     r_dest  [N];
`ifdef ALU_RS_AGE_PRIORITY_EN
  logic [2:0]       r_age   [N];
  logic [2:0]       w_best_age;
`endif

  logic             r_issue_valid;
  logic [WIDTH:0]   r_issue_a;
  logic [WIDTH:0]   r_issue_b;
  logic [A_WIDTH:0] r_issue_cntrl;
  logic [ROB:0]     r_issue_rob;

  logic [ALU:0]     w_elig;
  logic [ALU:0]     w_free;
  logic             w_any;
  logic             w_load;
  logic [SW-1:0]    w_sel;
  logic             w_disp_rdy1;
  logic             w_disp_rdy2;
  logic [WIDTH:0]   w_disp_val1;
  logic [WIDTH:0]   w_disp_val2;

  assign w_elig = r_valid & r_rdy1 & r_rdy2;
  assign w_load = !r_issue_valid || aluReady;

  // Operands not ready at dispatch can still be captured from a same-cycle broadcast.
  assign w_disp_rdy1 = ready1 || (cdbValid && cdbTag == rob1);
  assign w_disp_rdy2 = ready2 || (cdbValid && cdbTag == rob2);
  assign w_disp_val1 = ready1 ? value1 : cdbValue;
  assign w_disp_val2 = ready2 ? value2 : cdbValue;

  always_comb begin
    w_any = 1'b0;
    w_sel = '0;
`ifdef ALU_RS_AGE_PRIORITY_EN
    w_best_age = '0;
`endif
    for (int i = 0; i < N; i++) begin
`ifdef ALU_RS_AGE_PRIORITY_EN
      // Strictly-greater comparison keeps the lowest index on an age tie.
      if (w_elig[i] && (!w_any || r_age[i] > w_best_age)) begin
        w_any      = 1'b1;
        w_sel      = SW'(i);
        w_best_age = r_age[i];
      end
`else
      if (w_elig[i] && !w_any) begin
        w_any = 1'b1;
        w_sel = SW'(i);
      end
`endif
    end
  end

  assign w_free = (w_load && w_any) ? ((N)'(1) << w_sel) : '0;

  always_ff @(posedge clk) begin
    if (!resetN || flush) begin
      r_valid       <= '0;
      r_issue_valid <= 1'b0;
      r_issue_a     <= '0;
      r_issue_b     <= '0;
      r_issue_cntrl <= '0;
      r_issue_rob   <= '0;
    end else begin
      for (int i = 0; i < N; i++) begin
        if (ALURequests[i] && !r_valid[i]) begin
          r_valid[i] <= 1'b1;
          r_rdy1[i]  <= w_disp_rdy1;
          r_rdy2[i]  <= w_disp_rdy2;
          r_val1[i]  <= w_disp_val1;
          r_val2[i]  <= w_disp_val2;
          r_tag1[i]  <= rob1;
          r_tag2[i]  <= rob2;
          r_cntrl[i] <= aluCntrl;
          r_dest[i]  <= destRob;
`ifdef ALU_RS_AGE_PRIORITY_EN
          r_age[i]   <= '0;
`endif
        end else if (r_valid[i]) begin
          if (w_free[i]) r_valid[i] <= 1'b0;
          if (!r_rdy1[i] && cdbValid && cdbTag == r_tag1[i]) begin
            r_rdy1[i] <= 1'b1;
            r_val1[i] <= cdbValue;
          end
          if (!r_rdy2[i] && cdbValid && cdbTag == r_tag2[i]) begin
            r_rdy2[i] <= 1'b1;
            r_val2[i] <= cdbValue;
          end
`ifdef ALU_RS_AGE_PRIORITY_EN
          if (!w_free[i] && r_age[i] != 3'd7) r_age[i] <= r_age[i] + 3'd1;
`endif
        end
      end
      if (w_load) begin
        r_issue_valid <= w_any;
        if (w_any) begin
          r_issue_a     <= r_val1[w_sel];
          r_issue_b     <= r_val2[w_sel];
          r_issue_cntrl <= r_cntrl[w_sel];
          r_issue_rob   <= r_dest[w_sel];
        end
      end
    end
  end

  assign ALUBusyVector = r_valid;
  assign issueValid    = r_issue_valid;
  assign issueA        = r_issue_a;
  assign issueB        = r_issue_b;
  assign issueCntrl    = r_issue_cntrl;
  assign issueRob      = r_issue_rob;

endmodule

// File: tb/tb_alu_reservation_station.sv
// tb/tb_alu_reservation_station.sv - table-driven bench for alu_reservation_station
module tb_alu_reservation_station;
  logic        clk = 1'b0;
  logic        resetN, flush;
  logic [3:0]  ALURequests;
  logic [31:0] value1, value2;
  logic        ready1, ready2;
  logic [2:0]  rob1, rob2, destRob;
  logic [3:0]  aluCntrl;
  logic        cdbValid;
  logic [2:0]  cdbTag;
  logic [31:0] cdbValue;
  logic        aluReady;
  logic [3:0]  ALUBusyVector;
  logic        issueValid;
  logic [31:0] issueA, issueB;
  logic [3:0]  issueCntrl;
  logic [2:0]  issueRob;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  alu_reservation_station dut (
    .clk(clk), .resetN(resetN), .flush(flush), .ALURequests(ALURequests),
    .value1(value1), .value2(value2), .ready1(ready1), .ready2(ready2),
    .rob1(rob1), .rob2(rob2), .destRob(destRob), .aluCntrl(aluCntrl),
    .cdbValid(cdbValid), .cdbTag(cdbTag), .cdbValue(cdbValue), .aluReady(aluReady),
    .ALUBusyVector(ALUBusyVector), .issueValid(issueValid), .issueA(issueA),
    .issueB(issueB), .issueCntrl(issueCntrl), .issueRob(issueRob)
  );

  always @(posedge clk) begin
    if (resetN && !flush)
      assert ((ALURequests & ALUBusyVector) == 4'b0000) else $error("dispatch grant to occupied entry");
  end

  typedef struct {
    logic [3:0]  req;
    logic        r1;
    logic [31:0] v1;
    logic [2:0]  t1;
    logic        r2;
    logic [31:0] v2;
    logic [2:0]  t2;
    logic [2:0]  dest;
    logic [3:0]  cntrl;
    logic        dcv;
    logic [2:0]  dct;
    logic [31:0] dcval;
    logic        wcv;
    logic [2:0]  wct;
    logic [31:0] wcval;
    logic [31:0] ea;
    logic [31:0] eb;
    int          lat;
  } vec_t;

  vec_t vecs[5];
  vec_t v;
  int   lat;
  int   order[5];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  task automatic idle();
    flush = 1'b0; ALURequests = '0; value1 = '0; value2 = '0;
    ready1 = 1'b0; ready2 = 1'b0; rob1 = '0; rob2 = '0; destRob = '0;
    aluCntrl = '0; cdbValid = 1'b0; cdbTag = '0; cdbValue = '0; aluReady = 1'b1;
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic disp(input int e, input logic r1, input logic [31:0] v1, input logic [2:0] t1,
                      input logic r2, input logic [31:0] v2, input logic [2:0] t2,
                      input logic [2:0] d, input logic [3:0] c);
    ALURequests = 4'(1 << e);
    ready1 = r1; value1 = v1; rob1 = t1;
    ready2 = r2; value2 = v2; rob2 = t2;
    destRob = d; aluCntrl = c;
  endtask

  initial begin
    vecs[0] = '{req:4'b0001, r1:1, v1:32'd5, r2:1, v2:32'd7, dest:3'd3, cntrl:4'd0,
                ea:32'd5, eb:32'd7, lat:1, default:0};
    vecs[1] = '{req:4'b0010, r1:1, v1:32'h20, r2:0, t2:3'd2, dest:3'd5, cntrl:4'd2,
                wcv:1, wct:3'd2, wcval:32'h10, ea:32'h20, eb:32'h10, lat:2, default:0};
    vecs[2] = '{req:4'b0100, r1:0, t1:3'd4, r2:1, v2:32'd3, dest:3'd1, cntrl:4'd7,
                dcv:1, dct:3'd4, dcval:32'd9, ea:32'd9, eb:32'd3, lat:1, default:0};
    vecs[3] = '{req:4'b1000, r1:0, t1:3'd6, r2:0, t2:3'd6, dest:3'd6, cntrl:4'hf,
                wcv:1, wct:3'd6, wcval:32'habcd, ea:32'habcd, eb:32'habcd, lat:2, default:0};
    vecs[4] = '{req:4'b0001, r1:1, v1:32'hffffffff, t1:3'd0, r2:0, t2:3'd0, dest:3'd7, cntrl:4'd5,
                dcv:1, dct:3'd0, dcval:32'h80000000, ea:32'hffffffff, eb:32'h80000000, lat:1, default:0};
`ifdef ALU_RS_AGE_PRIORITY_EN
    order = '{0, 1, 2, 3, 4};
`else
    order = '{0, 3, 2, 1, 4};
`endif

    idle();
    resetN = 1'b0;
    step(); step();
    resetN = 1'b1;
    chk("reset_busy", 32'(ALUBusyVector), 32'd0);
    chk("reset_issue_valid", 32'(issueValid), 32'd0);

    for (int k = 0; k < 5; k++) begin
      v = vecs[k];
      idle();
      disp(0, v.r1, v.v1, v.t1, v.r2, v.v2, v.t2, v.dest, v.cntrl);
      ALURequests = v.req;
      cdbValid = v.dcv; cdbTag = v.dct; cdbValue = v.dcval;
      step();
      chk($sformatf("v%0d_busy_after_dispatch", k), 32'(ALUBusyVector), 32'(v.req));
      idle();
      cdbValid = v.wcv; cdbTag = v.wct; cdbValue = v.wcval;
      lat = 0;
      while (lat < 6) begin
        step();
        lat++;
        idle();
        if (issueValid) break;
      end
      chk($sformatf("v%0d_latency", k), 32'(lat), 32'(v.lat));
      chk($sformatf("v%0d_issueA", k), issueA, v.ea);
      chk($sformatf("v%0d_issueB", k), issueB, v.eb);
      chk($sformatf("v%0d_issueRob", k), 32'(issueRob), 32'(v.dest));
      chk($sformatf("v%0d_issueCntrl", k), 32'(issueCntrl), 32'(v.cntrl));
      chk($sformatf("v%0d_busy_freed", k), 32'(ALUBusyVector), 32'd0);
      step();
      chk($sformatf("v%0d_issue_drops", k), 32'(issueValid), 32'd0);
    end

    // A broadcast with the wrong tag must leave the entry asleep.
    idle();
    disp(1, 1'b1, 32'h1, 3'd0, 1'b0, 32'h0, 3'd2, 3'd2, 4'd3);
    step();
    idle(); cdbValid = 1'b1; cdbTag = 3'd1; cdbValue = 32'h55;
    step();
    idle();
    chk("mismatch_no_wake", 32'(issueValid), 32'd0);
    chk("mismatch_busy", 32'(ALUBusyVector), 32'b0010);
    step();
    chk("mismatch_still_idle", 32'(issueValid), 32'd0);
    cdbValid = 1'b1; cdbTag = 3'd2; cdbValue = 32'h10;
    step();
    idle();
    chk("wake_not_same_edge", 32'(issueValid), 32'd0);
    step();
    chk("wake_issue_valid", 32'(issueValid), 32'd1);
    chk("wake_issueB", issueB, 32'h10);
    chk("wake_issueA", issueA, 32'h1);
    step();
    chk("wake_issue_drops", 32'(issueValid), 32'd0);

    // Fill the station behind a stalled issue register, then drain.
    idle(); aluReady = 1'b0;
    disp(3, 1'b1, 32'ha0, 3'd0, 1'b1, 32'ha1, 3'd0, 3'd0, 4'd1); step();
    disp(2, 1'b1, 32'hb0, 3'd0, 1'b1, 32'hb1, 3'd0, 3'd1, 4'd1); step();
    disp(1, 1'b1, 32'hc0, 3'd0, 1'b1, 32'hc1, 3'd0, 3'd2, 4'd1); step();
    disp(0, 1'b1, 32'hd0, 3'd0, 1'b1, 32'hd1, 3'd0, 3'd3, 4'd1); step();
    disp(3, 1'b1, 32'he0, 3'd0, 1'b1, 32'he1, 3'd0, 3'd4, 4'd1); step();
    idle(); aluReady = 1'b0;
    chk("full_busy", 32'(ALUBusyVector), 32'b1111);
    chk("full_issue_valid", 32'(issueValid), 32'd1);
    chk("full_issueA", issueA, 32'ha0);
    for (int h = 0; h < 2; h++) begin
      step();
      chk($sformatf("hold%0d_busy", h), 32'(ALUBusyVector), 32'b1111);
      chk($sformatf("hold%0d_issueRob", h), 32'(issueRob), 32'(order[0]));
      chk($sformatf("hold%0d_issue_valid", h), 32'(issueValid), 32'd1);
    end
    aluReady = 1'b1;
    for (int k = 1; k < 5; k++) begin
      step();
      chk($sformatf("drain%0d_issueRob", k), 32'(issueRob), 32'(order[k]));
      chk($sformatf("drain%0d_issue_valid", k), 32'(issueValid), 32'd1);
    end
    step();
    chk("drain_done_valid", 32'(issueValid), 32'd0);
    chk("drain_done_busy", 32'(ALUBusyVector), 32'd0);

    // Flush beats a concurrent dispatch and CDB hit.
    idle(); aluReady = 1'b0;
    disp(0, 1'b1, 32'h11, 3'd0, 1'b1, 32'h12, 3'd0, 3'd5, 4'd2); step();
    disp(1, 1'b1, 32'h21, 3'd0, 1'b1, 32'h22, 3'd0, 3'd6, 4'd2); step();
    disp(2, 1'b1, 32'h31, 3'd0, 1'b1, 32'h32, 3'd0, 3'd7, 4'd2); step();
    disp(3, 1'b1, 32'h41, 3'd0, 1'b0, 32'h0, 3'd5, 3'd1, 4'd2); step();
    idle(); aluReady = 1'b0;
    chk("preflush_busy", 32'(ALUBusyVector), 32'b1110);
    chk("preflush_issue_valid", 32'(issueValid), 32'd1);
    disp(0, 1'b1, 32'h51, 3'd0, 1'b1, 32'h52, 3'd0, 3'd2, 4'd4);
    flush = 1'b1; cdbValid = 1'b1; cdbTag = 3'd5; cdbValue = 32'h77;
    step();
    idle();
    chk("flush_busy", 32'(ALUBusyVector), 32'd0);
    chk("flush_issue_valid", 32'(issueValid), 32'd0);
    chk("flush_issueRob", 32'(issueRob), 32'd0);
    chk("flush_issueA", issueA, 32'd0);
    step();
    chk("flush_dispatch_dropped", 32'(ALUBusyVector), 32'd0);
    chk("flush_no_issue", 32'(issueValid), 32'd0);

    // Reset from a busy state clears everything.
    idle(); aluReady = 1'b0;
    disp(0, 1'b1, 32'h1234, 3'd0, 1'b1, 32'h5678, 3'd0, 3'd7, 4'd9); step();
    disp(1, 1'b1, 32'h9, 3'd0, 1'b1, 32'h9, 3'd0, 3'd3, 4'd9); step();
    idle(); aluReady = 1'b0;
    chk("prereset_issue_valid", 32'(issueValid), 32'd1);
    chk("prereset_busy", 32'(ALUBusyVector), 32'b0010);
    resetN = 1'b0;
    step();
    resetN = 1'b1;
    chk("rst_busy", 32'(ALUBusyVector), 32'd0);
    chk("rst_issue_valid", 32'(issueValid), 32'd0);
    chk("rst_issueA", issueA, 32'd0);
    chk("rst_issueB", issueB, 32'd0);
    chk("rst_issueCntrl", 32'(issueCntrl), 32'd0);
    chk("rst_issueRob", 32'(issueRob), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/alu_reservation_station.md
# alu_reservation_station

Four-entry ALU reservation station directly downstream of the rename stage. It captures renamed ALU instructions into the entry granted by the dispatch arbiter and holds unready operands until their ROB tag appears on the common data bus. It issues one ready instruction per cycle to the ALU through a registered valid/ready handshake. It reports per-entry occupancy back to the arbiter.

## Interface
Parameters:
- WIDTH, 31, operand/result MSB index (data is WIDTH+1 bits)
- A_WIDTH, 3, ALU control MSB index
- ROB, 2, ROB tag MSB index
- ALU, 3, entry-vector MSB index (ALU+1 = 4 entries)

Ports:
- clk  in  1  clock
- resetN  in  1  reset; one clock, synchronous, active-low
- flush  in  1  mispredict squash; clears the station
- ALURequests  in  ALU+1  one-hot dispatch grant; all-zero = no dispatch
- value1, value2  in  WIDTH+1  operand value, valid when the matching ready bit is set
- ready1, ready2  in  1  operand already available
- rob1, rob2  in  ROB+1  producer tag for an operand that is not ready
- destRob  in  ROB+1  ROB tag of the dispatched instruction
- aluCntrl  in  A_WIDTH+1  ALU operation
- cdbValid  in  1  CDB broadcast valid
- cdbTag  in  ROB+1  broadcast producer tag
- cdbValue  in  WIDTH+1  broadcast result
- aluReady  in  1  ALU accepts the issue register this cycle
- ALUBusyVector  out  ALU+1  entry occupied, one bit per entry
- issueValid  out  1  issue register holds an instruction
- issueA, issueB  out  WIDTH+1  operands
- issueCntrl  out  A_WIDTH+1  ALU operation
- issueRob  out  ROB+1  destination tag

## Operation
- Each entry holds: valid, rdy1, rdy2, val1, val2, tag1, tag2, cntrl, dest, and, under the age macro, age[2:0].
- Dispatch writes every field of entry i when ALURequests[i]=1 and flush=0.
  - Operand k sets rdyk=readyk and valk=valuek.
  - If readyk=0 and cdbValid=1 and cdbTag=robk in the same cycle, store rdyk=1 and valk=cdbValue (bypass).
- A dispatch grant to an entry that is already valid is illegal. The RTL ignores the write, and the bench asserts it never occurs.
- Wakeup: for every valid entry and each operand with rdyk=0, a cdbValid=1 with cdbTag=tagk sets rdyk=1 and valk=cdbValue at the edge.
  - One broadcast may wake both operands of several entries.
- Eligibility: valid & rdy1 & rdy2, from registered state only. An entry woken or written at edge N is eligible from cycle N onward.
- Issue register loads when issueValid=0 or aluReady=1.
  - If some entry is eligible: load the selected entry, set issueValid=1, and clear that entry's valid at the same edge.
  - Otherwise: issueValid=0.
- When the issue register is held (issueValid=1, aluReady=0), its contents stay stable and no entry is freed.
- Selection without the age macro: lowest-index eligible entry.
- ALUBusyVector = registered entry valid bits. A freed entry can be regranted the next cycle.
- The arbiter asserts ALUFull itself from ALUBusyVector. This block does not generate it.

## Timing
- Reset (resetN=0 at an edge): all entry valids=0, ALUBusyVector=0, issueValid=0. issueA/issueB/issueCntrl/issueRob=0, and entry data is don't-care.
- flush=1 at an edge gives the same effect as reset. Priority: reset > flush > dispatch/wakeup/issue.
- Dispatch with both operands ready, station otherwise empty, aluReady=1:
  - entry valid after edge N;
  - issueValid=1 after edge N+1;
  - entry freed at edge N+1.
- CDB wakeup at cycle c (tag captured at edge c): entry issues at edge c+1 at the earliest.
- Full station (ALUBusyVector=4'b1111) with issue stalled: state holds. Dispatch is impossible because the arbiter grants none.

## Configuration
- ALU_RS_AGE_PRIORITY_EN defined: oldest-first selection.
  - age is set to 0 on dispatch.
  - Each cycle, every valid entry not being freed increments age, saturating at 7.
  - Selection picks the eligible entry with the largest age; ties go to the lowest index.
- ALU_RS_AGE_PRIORITY_EN undefined: no age storage, and selection is lowest-index eligible.

## Test plan
- Reset, then dispatch to entry 0 with ready1=ready2=1, value1=5, value2=7, aluCntrl=0, destRob=3, aluReady=1 -> issueValid=1 two edges later with issueA=5, issueB=7, issueRob=3; ALUBusyVector returns to 0.
- Dispatch to entry 1 with ready2=0, rob2=2; later cdbValid=1, cdbTag=2, cdbValue=0x10 -> issueB=0x10 and issue one edge after the broadcast; a mismatched tag (1) does not wake the entry.
- Dispatch with ready1=0, rob1=4 in the same cycle as cdbValid=1, cdbTag=4, cdbValue=9 -> bypass captured; issueA=9 with no further broadcast.
- Fill all 4 entries ready while aluReady=0 -> ALUBusyVector=4'b1111, issue register stable. Raise aluReady -> one issue per cycle; order is entries 0,1,2,3 without the macro, and dispatch order when ALU_RS_AGE_PRIORITY_EN is defined and dispatch was 3,2,1,0.
- Three occupied entries plus issueValid=1, then flush=1 concurrent with a dispatch grant and a CDB hit -> next cycle ALUBusyVector=0, issueValid=0, and the dispatch is dropped.
